// File: rtl/sd_otf_converter.sv
// Serial signed-digit (MSD first) to two's-complement converter using on-the-fly
// conversion: Q/QM pair updated per digit, so the word is ready right after the last digit.
module sd_otf_converter #(
  parameter int DIGITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            digit_valid,
  input  logic            digit_p,
  input  logic            digit_n,
  output logic [DIGITS:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            abort
);

  localparam int CW = $clog2(DIGITS);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          r_state, w_stateNext;
  logic [CW-1:0]   r_cnt, w_cntNext;
  logic [DIGITS:0] r_q, r_qm;
  logic [DIGITS:0] w_qBase, w_qmBase, w_qNext, w_qmNext;
  logic            w_accept, w_last, w_abort, w_plus, w_minus;
  logic            w_resultValidNext, w_busyNext, w_abortNext;

  assign w_plus   = digit_p & ~digit_n;
  assign w_minus  = digit_n & ~digit_p;
  assign w_accept = digit_valid && (start || r_state == RUN);
  assign w_last   = digit_valid && !start && r_state == RUN && r_cnt == LAST;
  assign w_abort  = digit_valid && start && r_state == RUN;

  // A start digit restarts the pair from Q=0, QM=-1 regardless of stale contents
  always_comb begin
    w_qBase  = start ? '0 : r_q;
    w_qmBase = start ? '1 : r_qm;
    w_qNext  = {w_qBase[DIGITS-1:0], 1'b0};
    w_qmNext = {w_qmBase[DIGITS-1:0], 1'b1};
    if (w_plus) begin
      w_qNext  = {w_qBase[DIGITS-1:0], 1'b1};
      w_qmNext = {w_qBase[DIGITS-1:0], 1'b0};
    end else if (w_minus) begin
      w_qNext  = {w_qmBase[DIGITS-1:0], 1'b1};
      w_qmNext = {w_qmBase[DIGITS-1:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_q     <= '0;
      r_qm    <= '1;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      if (w_accept) begin
        r_q  <= w_qNext;
        r_qm <= w_qmNext;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (digit_valid && start) begin
          w_stateNext = RUN;
          w_cntNext   = CW'(1);
        end
      end
      RUN: begin
        if (digit_valid && start) begin
          w_cntNext = CW'(1);
        end else if (w_last) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
        end else if (digit_valid) begin
          w_cntNext = r_cnt + CW'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    w_resultValidNext = w_last;
    w_abortNext       = w_abort;
    w_busyNext        = (w_stateNext == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      abort        <= 1'b0;
    end else begin
      result_valid <= w_resultValidNext;
      busy         <= w_busyNext;
      abort        <= w_abortNext;
      if (w_last) result <= w_qNext;
    end
  end

endmodule

// File: tb/tb_sd_otf_converter.sv
// Directed bench for sd_otf_converter with DIGITS=4 (5-bit results); each scenario
// task drives digits on the falling edge and checks registered outputs just after the rising edge.
module tb_sd_otf_converter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       digit_valid;
  logic       digit_p;
  logic       digit_n;
  logic [4:0] result;
  logic       result_valid;
  logic       busy;
  logic       abort;

  int errors = 0;
  int checks = 0;

  sd_otf_converter #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digit_valid(digit_valid),
    .digit_p(digit_p), .digit_n(digit_n), .result(result),
    .result_valid(result_valid), .busy(busy), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drivePn(input logic s, input logic v, input logic p, input logic n);
    @(negedge clk);
    start = s; digit_valid = v; digit_p = p; digit_n = n;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input int d);
    drivePn(s, v, d == 1, d == -1);
  endtask

  task automatic test_reset;
    checks++; if (result !== 5'd0) begin errors++; $display("[TB] FAIL reset_result got=%b want=%b", result, 5'd0); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    checks++; if (abort !== 1'b0) begin errors++; $display("[TB] FAIL reset_abort got=%b want=0", abort); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_values;
    int vals[3][4] = '{'{1, 0, -1, 1}, '{-1, -1, -1, -1}, '{1, -1, 0, 0}};
    logic [4:0] expv[3] = '{5'b00111, 5'b10001, 5'b00100};
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 4; i++) begin
        drive(i == 0, 1'b1, vals[w][i]);
        if (i < 3) begin
          checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL values_mid w=%0d i=%0d valid=%b busy=%b want valid=0 busy=1", w, i, result_valid, busy); end
        end else begin
          checks++; if (result !== expv[w]) begin errors++; $display("[TB] FAIL values_result w=%0d got=%b want=%b", w, result, expv[w]); end
          checks++; if (result_valid !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL values_done w=%0d valid=%b busy=%b want valid=1 busy=0", w, result_valid, busy); end
        end
      end
      drive(1'b0, 1'b0, 0);
      checks++; if (result_valid !== 1'b0 || result !== expv[w]) begin errors++; $display("[TB] FAIL values_hold w=%0d valid=%b result=%b want valid=0 result=%b", w, result_valid, result, expv[w]); end
    end
  endtask

  task automatic test_gaps;
    logic [1:0] pn[4] = '{2'b10, 2'b00, 2'b11, 2'b01};
    for (int i = 0; i < 4; i++) begin
      drivePn(i == 0, 1'b1, pn[i][1], pn[i][0]);
      if (i < 3) begin
        checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL gaps_digit i=%0d valid=%b busy=%b want valid=0 busy=1", i, result_valid, busy); end
        for (int g = 0; g < 3; g++) begin
          drivePn(1'b0, 1'b0, 1'b1, 1'b0);
          checks++; if (result_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL gaps_idle i=%0d g=%0d valid=%b busy=%b want valid=0 busy=1", i, g, result_valid, busy); end
        end
      end
    end
    checks++; if (result !== 5'b00111 || result_valid !== 1'b1) begin errors++; $display("[TB] FAIL gaps_result got=%b valid=%b want=00111 valid=1", result, result_valid); end
    drive(1'b0, 1'b0, 0);
  endtask

  task automatic test_abort;
    int word[4] = '{-1, 0, 0, 0};
    int pulses = 0;
    int aborts = 0;
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b1, word[i]);
      if (result_valid) pulses++;
      if (abort) aborts++;
      if (i == 0) begin
        checks++; if (abort !== 1'b1 || busy !== 1'b1 || result !== 5'b00111) begin errors++; $display("[TB] FAIL abort_pulse abort=%b busy=%b result=%b want abort=1 busy=1 result=00111", abort, busy, result); end
      end
    end
    checks++; if (result !== 5'b11000) begin errors++; $display("[TB] FAIL abort_result got=%b want=11000", result); end
    drive(1'b0, 1'b0, 0);
    if (result_valid) pulses++;
    if (abort) aborts++;
    checks++; if (pulses != 1 || aborts != 1) begin errors++; $display("[TB] FAIL abort_counts valid_pulses=%0d aborts=%0d want 1 and 1", pulses, aborts); end
  endtask

  task automatic test_back_to_back;
    int words[2][4] = '{'{1, 1, 1, 1}, '{0, 0, 0, -1}};
    logic [4:0] expv[2] = '{5'b01111, 5'b11111};
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        drive(i == 0, 1'b1, words[w][i]);
        if (i == 0 && w == 1) begin
          checks++; if (result_valid !== 1'b0 || busy !== 1'b1 || abort !== 1'b0) begin errors++; $display("[TB] FAIL b2b_second_start valid=%b busy=%b abort=%b want 0 1 0", result_valid, busy, abort); end
        end
      end
      checks++; if (result !== expv[w] || result_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_result w=%0d got=%b valid=%b want=%b valid=1", w, result, result_valid, expv[w]); end
    end
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b1, -1);
    checks++; if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 5'b11111) begin errors++; $display("[TB] FAIL stray_ignored busy=%b valid=%b result=%b want 0 0 11111", busy, result_valid, result); end
  endtask

  task automatic test_reset_midword;
    int word[4] = '{1, 0, 0, 0};
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 1);
    @(negedge clk);
    start = 1'b0; digit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (result !== 5'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_midword result=%b busy=%b want 00000 0", result, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 1'b1, word[i]);
      if (i == 1) begin
        checks++; if (busy !== 1'b1 || result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_newword_mid busy=%b valid=%b want 1 0", busy, result_valid); end
      end
    end
    checks++; if (result !== 5'b01000 || result_valid !== 1'b1) begin errors++; $display("[TB] FAIL reset_newword got=%b valid=%b want=01000 valid=1", result, result_valid); end
    drive(1'b0, 1'b0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; digit_valid = 1'b0; digit_p = 1'b0; digit_n = 1'b0;
    #12;
    test_reset;
    test_values;
    test_gaps;
    test_abort;
    test_back_to_back;
    test_reset_midword;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
